// File: rtl/shift_sequencer.sv
// shift_sequencer: command-driven controller for the 8-bit load/rotate/ASR
// datapath. Takes one {op, amount, data} command, loads the datapath, steps it
// the requested number of times, then presents the datapath Q as the result.
// The datapath has no hold mode, so idle and done states reload Q into itself.
// Optional feature macro: SHIFT_SEQ_ABORT_EN (adds abort / res_aborted).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a command, datapath holding its own Q
// S_LOAD  | parallel-loading the latched command data into the datapath
// S_SHIFT | stepping the datapath once per edge until cnt runs out
// S_DONE  | result presented on res_data until the consumer takes it
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amount,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             ParallelLoadn,
    output logic             RotateRight,
    output logic             ASRight,
    output logic [WIDTH-1:0] Data_IN,
    input  logic [WIDTH-1:0] q_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data
`ifdef SHIFT_SEQ_ABORT_EN
    ,
    input  logic             abort,
    output logic             res_aborted
`endif
);

    localparam logic [1:0] OP_ROR  = 2'b00;
    localparam logic [1:0] OP_ROL  = 2'b01;
    localparam logic [1:0] OP_ASR  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [AMT_W-1:0] cnt, cnt_nx;
    logic [1:0]       op_q, op_nx;
    logic [WIDTH-1:0] data_q, data_nx;
`ifdef SHIFT_SEQ_ABORT_EN
    logic             aborted_q, aborted_nx;
`endif

    // State, step counter and latched command registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            data_q <= '0;
`ifdef SHIFT_SEQ_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            op_q   <= op_nx;
            data_q <= data_nx;
`ifdef SHIFT_SEQ_ABORT_EN
            aborted_q <= aborted_nx;
`endif
        end
    end

    // Next-state and datapath control decode from the registered state.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        op_nx         = op_q;
        data_nx       = data_q;
        cmd_ready     = 1'b0;
        res_valid     = 1'b0;
        res_data      = '0;
        ParallelLoadn = 1'b0;
        RotateRight   = 1'b0;
        ASRight       = 1'b0;
        Data_IN       = q_in;
`ifdef SHIFT_SEQ_ABORT_EN
        aborted_nx    = aborted_q;
`endif
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_nx    = cmd_op;
                    data_nx  = cmd_data;
                    // LOAD-only never shifts, whatever amount came with it.
                    cnt_nx   = (cmd_op == OP_LOAD) ? '0 : cmd_amount;
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                Data_IN  = data_q;
                state_nx = (cnt != '0) ? S_SHIFT : S_DONE;
`ifdef SHIFT_SEQ_ABORT_EN
                // The load still lands; only the shifting is skipped.
                if (abort) begin
                    state_nx   = S_DONE;
                    cnt_nx     = '0;
                    aborted_nx = 1'b1;
                end
`endif
            end
            S_SHIFT: begin
                ParallelLoadn = 1'b1;
                RotateRight   = (op_q != OP_ROL);
                ASRight       = (op_q == OP_ASR);
                cnt_nx        = cnt - 1'b1;
                if (cnt == AMT_W'(1)) begin
                    state_nx = S_DONE;
                end
`ifdef SHIFT_SEQ_ABORT_EN
                // The abort edge reloads Q so no partial extra step occurs.
                if (abort) begin
                    ParallelLoadn = 1'b0;
                    RotateRight   = 1'b0;
                    ASRight       = 1'b0;
                    Data_IN       = q_in;
                    cnt_nx        = '0;
                    state_nx      = S_DONE;
                    aborted_nx    = 1'b1;
                end
`endif
            end
            S_DONE: begin
                res_valid = 1'b1;
                res_data  = q_in;
                if (res_ready) begin
                    state_nx = S_IDLE;
`ifdef SHIFT_SEQ_ABORT_EN
                    aborted_nx = 1'b0;
`endif
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef SHIFT_SEQ_ABORT_EN
    assign res_aborted = aborted_q;
`endif

endmodule
